// File: rtl/fifo_wr_packer_if.sv
// Byte-lane input stream and FIFO write port seen by the write-side packer.
interface fifo_wr_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int WIDTH    = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_data;
    logic                in_last;
    logic                fifo_wr_en;
    logic [WIDTH-1:0]    fifo_wr_data;
    logic                fifo_wr_valid;

    // slave = packer, master = beat producer plus the FIFO's acceptance output
    modport slave (
        input  in_valid, in_data, in_last, fifo_wr_valid,
        output in_ready, fifo_wr_en, fifo_wr_data
    );
    modport master (
        output in_valid, in_data, in_last, fifo_wr_valid,
        input  in_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats into one FIFO word via an accumulator and a hold register;
// in_last closes a word early with zero-padded upper lanes.
module fifo_wr_packer #(
    parameter int IN_WIDTH = 8,
    parameter int WIDTH    = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    fifo_wr_packer_if.slave   bus,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  pad_count,
    output logic              busy
);
    localparam int RATIO  = WIDTH / IN_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              acc_full_q, acc_full_d;
    logic              acc_pad_q, acc_pad_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              hold_pad_q, hold_pad_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  pad_cnt_q, pad_cnt_d;

    logic accept;
    logic close_word;
    logic write_taken;
    logic xfer;

    assign accept      = bus.in_valid && !acc_full_q;
    assign close_word  = (lane_q == LAST_LANE) || bus.in_last;
    assign write_taken = hold_valid_q && bus.fifo_wr_valid;
    // The hold slot is free when empty or being written this very cycle: no bubble.
    assign xfer        = acc_full_q && (!hold_valid_q || write_taken);

    always_comb begin
        acc_d        = acc_q;
        lane_d       = lane_q;
        acc_full_d   = acc_full_q;
        acc_pad_d    = acc_pad_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        hold_pad_d   = hold_pad_q;
        word_cnt_d   = word_cnt_q;
        pad_cnt_d    = pad_cnt_q;

        if (accept) begin
            // A new word starts from zero so short words never carry stale lanes.
            if (lane_q == '0) begin
                acc_d = '0;
            end
            acc_d[int'(lane_q)*IN_WIDTH +: IN_WIDTH] = bus.in_data;
            if (close_word) begin
                acc_full_d = 1'b1;
                lane_d     = '0;
                acc_pad_d  = (lane_q != LAST_LANE);
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end

        if (write_taken) begin
            word_cnt_d   = word_cnt_q + CNT_W'(1);
            pad_cnt_d    = pad_cnt_q + CNT_W'(hold_pad_q);
            hold_valid_d = 1'b0;
        end

        if (xfer) begin
            hold_d       = acc_q;
            hold_valid_d = 1'b1;
            hold_pad_d   = acc_pad_q;
            acc_full_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            lane_q       <= '0;
            acc_full_q   <= 1'b0;
            acc_pad_q    <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_pad_q   <= 1'b0;
            word_cnt_q   <= '0;
            pad_cnt_q    <= '0;
        end else begin
            acc_q        <= acc_d;
            lane_q       <= lane_d;
            acc_full_q   <= acc_full_d;
            acc_pad_q    <= acc_pad_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            hold_pad_q   <= hold_pad_d;
            word_cnt_q   <= word_cnt_d;
            pad_cnt_q    <= pad_cnt_d;
        end
    end

    assign bus.in_ready     = !acc_full_q;
    assign bus.fifo_wr_en   = hold_valid_q;
    assign bus.fifo_wr_data = hold_valid_q ? hold_q : '0;
    assign word_count       = word_cnt_q;
    assign pad_count        = pad_cnt_q;
    assign busy             = (lane_q != '0) || acc_full_q || hold_valid_q;
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer; a second 4-bit-counter instance runs in lockstep
// so counter wrap can be reached in a few cycles.
module tb_fifo_wr_packer;
    logic        clock;
    logic        reset_n;
    logic        fifo_full;
    logic [15:0] word_count, pad_count;
    logic        busy;
    logic [3:0]  word_count2, pad_count2;
    logic        busy2;

    int n_checks = 0;
    int n_errors = 0;
    int stall_cycles = 0;
    logic [31:0] got_q[$];

    fifo_wr_packer_if #(.IN_WIDTH(8), .WIDTH(32)) bus ();
    fifo_wr_packer_if #(.IN_WIDTH(8), .WIDTH(32)) bus2 ();

    fifo_wr_packer #(.IN_WIDTH(8), .WIDTH(32), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .word_count(word_count), .pad_count(pad_count), .busy(busy)
    );

    fifo_wr_packer #(.IN_WIDTH(8), .WIDTH(32), .CNT_W(4)) dut_wrap (
        .clock(clock), .reset_n(reset_n), .bus(bus2),
        .word_count(word_count2), .pad_count(pad_count2), .busy(busy2)
    );

    // The FIFO model accepts whatever is offered unless it is full.
    assign bus.fifo_wr_valid  = bus.fifo_wr_en & ~fifo_full;
    assign bus2.in_valid      = bus.in_valid;
    assign bus2.in_data       = bus.in_data;
    assign bus2.in_last       = bus.in_last;
    assign bus2.fifo_wr_valid = bus2.fifo_wr_en & ~fifo_full;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.fifo_wr_en && bus.fifo_wr_valid) got_q.push_back(bus.fifo_wr_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int waits;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && waits < 50) begin
            tick();
            waits++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        stall_cycles += waits;
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n      = 1'b0;
        fifo_full    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("rst_wr_data", bus.fifo_wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_pad_count", 32'(pad_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Full word: enable rises one cycle after acc_full, write taken the cycle after that.
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b1);
        bus.in_valid = 1'b0;
        check("t1_in_ready_drop", 32'(bus.in_ready), 32'd0);
        check("t1_wr_en_early", 32'(bus.fifo_wr_en), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_wr_en", 32'(bus.fifo_wr_en), 32'd1);
        check("t1_wr_data", bus.fifo_wr_data, 32'h44332211);
        tick();
        check("t1_word_count", 32'(word_count), 32'd1);
        check("t1_pad_count", 32'(pad_count), 32'd0);
        check("t1_wr_en_after", 32'(bus.fifo_wr_en), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_nwords", got_q.size(), 32'd1);
        check("t1_word", got_q[0], 32'h44332211);

        // Short words closed by in_last
        got_q.delete();
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        send_beat(8'hCC, 1'b1);
        idle(4);
        check("t2_nwords", got_q.size(), 32'd2);
        check("t2_word0", got_q[0], 32'h0000BBAA);
        check("t2_word1", got_q[1], 32'h000000CC);
        check("t2_word_count", 32'(word_count), 32'd3);
        check("t2_pad_count", 32'(pad_count), 32'd2);

        // Backpressure from a full FIFO
        got_q.delete();
        fifo_full = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(8'(8'h20 + i), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h28;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_in_ready", 32'(bus.in_ready), 32'd0);
            check("t3_wr_en", 32'(bus.fifo_wr_en), 32'd1);
            check("t3_wr_data", bus.fifo_wr_data, 32'h23222120);
        end
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_count_held", 32'(word_count), 32'd3);
        fifo_full = 1'b0;
        for (int i = 8; i < 12; i++) send_beat(8'(8'h20 + i), 1'b0);
        idle(4);
        check("t3_nwords", got_q.size(), 32'd3);
        check("t3_word0", got_q[0], 32'h23222120);
        check("t3_word1", got_q[1], 32'h27262524);
        check("t3_word2", got_q[2], 32'h2B2A2928);
        check("t3_word_count", 32'(word_count), 32'd6);

        // 400-beat stream: one stall cycle per word except after the final word
        got_q.delete();
        stall_cycles = 0;
        for (int i = 0; i < 400; i++) send_beat(8'(i), 1'b0);
        idle(4);
        check("t4_stalls", 32'(stall_cycles), 32'd99);
        check("t4_nwords", got_q.size(), 32'd100);
        for (int k = 0; k < 100; k++) begin
            check("t4_word", got_q[k],
                  {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)});
        end
        check("t4_word_count", 32'(word_count), 32'd106);
        check("t4_pad_count", 32'(pad_count), 32'd2);

        // Asynchronous reset with a word held and a partial word in the accumulator
        got_q.delete();
        fifo_full = 1'b1;
        send_beat(8'h51, 1'b0);
        send_beat(8'h52, 1'b0);
        send_beat(8'h53, 1'b0);
        send_beat(8'h54, 1'b0);
        send_beat(8'h61, 1'b0);
        send_beat(8'h62, 1'b0);
        bus.in_valid = 1'b0;
        check("t5_held", 32'(bus.fifo_wr_en), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("t5_wr_data", bus.fifo_wr_data, 32'd0);
        check("t5_word_count", 32'(word_count), 32'd0);
        check("t5_pad_count", 32'(pad_count), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5_wrap_count", 32'(word_count2), 32'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        fifo_full = 1'b0;
        tick();
        send_beat(8'h71, 1'b0);
        send_beat(8'h72, 1'b0);
        send_beat(8'h73, 1'b0);
        send_beat(8'h74, 1'b0);
        idle(4);
        check("t5_nwords", got_q.size(), 32'd1);
        check("t5_word", got_q[0], 32'h74737271);
        check("t5_word_count_after", 32'(word_count), 32'd1);

        // Counter wrap on the narrow-counter instance
        for (int i = 0; i < 14; i++) send_beat(8'(8'h80 + i), 1'b1);
        idle(4);
        check("t6_word_count", 32'(word_count), 32'd15);
        check("t6_pad_count", 32'(pad_count), 32'd14);
        check("t6_wrap_pre", 32'(word_count2), 32'hF);
        check("t6_wrap_pad_pre", 32'(pad_count2), 32'hE);
        send_beat(8'hEE, 1'b1);
        idle(4);
        check("t6_wrap", 32'(word_count2), 32'h0);
        check("t6_word_count_16", 32'(word_count), 32'd16);
        check("t6_last_word", got_q[got_q.size() - 1], 32'h000000EE);
        check("t6_idle_busy2", 32'(busy2), 32'd0);
        check("t6_idle_ready2", 32'(bus2.in_ready), 32'd1);
        check("t6_idle_data2", bus2.fifo_wr_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
